apb4_ps2_ctrl: RTL and testbench

APB4-slave PS/2 receive controller for the SoC peripheral bus. It samples an external PS/2 device's clock and data lines and decodes 11-bit frames. Valid bytes are buffered in a FIFO and exposed through three memory-mapped registers, with a level interrupt to the interrupt controller.

---
 rtl/apb4_ps2_ctrl.sv | 172 +++++++++++++++++
 tb/tb_apb4_ps2_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/apb4_ps2_ctrl.sv
// rtl/apb4_ps2_ctrl.sv - APB4 PS/2 receive controller with byte FIFO and level interrupt
module apb4_ps2_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] paddr,
    input  logic [2:0]  pprot,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] prdata,
    input  logic        ps2_clk_i,
    input  logic        ps2_dat_i,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          fall;
    logic          bit_in;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] tmo_cnt;
    logic          frame_done;
    logic          frame_ok;
    logic          push_req;
    logic          perr_set;
    logic          ctrl_en;
    logic          ctrl_itn;
    logic          ovf;
    logic          perr;
    logic          irq_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          full;
    logic          nempty;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          wr_en;
    logic          rd_acc;
    logic [1:0]    reg_sel;
    logic [4:0]    cnt_field;
    logic          unused_ok;

    assign pready    = 1'b1;
    assign pslverr   = 1'b0;
    assign irq_o     = irq_q;
    assign unused_ok = ^{pprot, pstrb, paddr[31:4], paddr[1:0], pwdata[31:3]};

    // Synchronizers idle high so reset never looks like a falling edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_i};
            dat_sync <= {dat_sync[0], ps2_dat_i};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = dat_sync[1];

    // shreg[0] holds start, [8:1] the data byte, [9] parity once 10 bits are in
    assign frame_done = ctrl_en & fall & (bit_cnt == 4'd10);
    assign frame_ok   = ~shreg[0] & bit_in & (^shreg[9:1]);
    assign push_req   = frame_done & frame_ok;
    assign perr_set   = frame_done & ~frame_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i || !ctrl_en) begin
            bit_cnt <= 4'd0;
            tmo_cnt <= '0;
            shreg   <= '0;
        end else if (fall) begin
            tmo_cnt <= '0;
            shreg   <= {bit_in, shreg[9:1]};
            bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
        end else if (bit_cnt != 4'd0) begin
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                bit_cnt <= 4'd0;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    assign wr_en   = psel & penable & pwrite;
    assign rd_acc  = psel & penable & ~pwrite;
    assign reg_sel = paddr[3:2];
    assign nempty  = (count != '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = rd_acc & (reg_sel == 2'd1) & nempty;
    // A pop on the same edge frees the slot a full-FIFO push needs
    assign push    = push_req & (~full | pop);
    assign ovf_set = push_req & full & ~pop;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= shreg[8:1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set on the same edge as a W1C clear wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en  <= 1'b0;
            ctrl_itn <= 1'b0;
            ovf      <= 1'b0;
            perr     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && reg_sel == 2'd0) begin
                ctrl_en  <= pwdata[0];
                ctrl_itn <= pwdata[1];
            end
            ovf   <= ovf_set  | (ovf  & ~(wr_en & (reg_sel == 2'd2) & pwdata[1]));
            perr  <= perr_set | (perr & ~(wr_en & (reg_sel == 2'd2) & pwdata[2]));
            irq_q <= ctrl_itn & nempty;
        end
    end

    assign cnt_field = 5'(count);

    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            case (reg_sel)
                2'd0:    prdata[1:0] = {ctrl_itn, ctrl_en};
                2'd1:    prdata[7:0] = nempty ? mem[rptr] : 8'h00;
                2'd2:    prdata[7:0] = {cnt_field, perr, ovf, nempty};
                default: prdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_apb4_ps2_ctrl.sv
// tb/tb_apb4_ps2_ctrl.sv - randomized self-checking bench for apb4_ps2_ctrl against a queue model
module tb_apb4_ps2_ctrl;
    localparam int DEPTH = 16;
    localparam int TMO   = 200;
    localparam int HALF  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        ps2_clk;
    logic        ps2_dat;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned mq[$];
    bit m_en, m_itn, m_ovf, m_perr;

    always #5 clk = ~clk;

    apb4_ps2_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .paddr(paddr), .pprot(pprot), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .pslverr(pslverr), .prdata(prdata),
        .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat), .irq_o(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        d = prdata;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic write_ctrl(input logic [31:0] d);
        apb_write(32'h0, d);
        m_en  = d[0];
        m_itn = d[1];
    endtask

    task automatic write_stat(input logic [31:0] d);
        apb_write(32'h8, d);
        if (d[1]) m_ovf = 1'b0;
        if (d[2]) m_perr = 1'b0;
    endtask

    task automatic check_data(input string tag);
        logic [31:0] v;
        logic [31:0] exp;
        apb_read(32'h4, v);
        exp = (mq.size() != 0) ? 32'(mq.pop_front()) : 32'h0;
        check(tag, v, exp);
    endtask

    task automatic check_stat(input string tag);
        logic [31:0] v;
        logic [31:0] exp;
        apb_read(32'h8, v);
        exp = (mq.size() * 8) + (m_perr ? 4 : 0) + (m_ovf ? 2 : 0) + ((mq.size() != 0) ? 1 : 0);
        check(tag, v, exp);
    endtask

    task automatic check_irq(input string tag);
        repeat (2) @(negedge clk);
        check(tag, {31'b0, irq}, {31'b0, m_itn && (mq.size() != 0)});
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // corrupt: 0 good, 1 wrong parity, 2 start=1, 3 stop=0
    task automatic send_frame(input logic [7:0] d, input int corrupt);
        logic [10:0] bits;
        bits[0]   = (corrupt == 2);
        bits[8:1] = d;
        bits[9]   = ~(^d) ^ (corrupt == 1);
        bits[10]  = (corrupt != 3);
        send_bits(bits, 11);
        if (m_en) begin
            if (corrupt != 0) m_perr = 1'b1;
            else if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        rst = 1'b1; paddr = '0; pprot = '0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pstrb = 4'hF; ps2_clk = 1'b1; ps2_dat = 1'b1;
        m_en = 0; m_itn = 0; m_ovf = 0; m_perr = 0;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        apb_read(32'h0, v); check("reset_ctrl", v, 32'h0);
        apb_read(32'h4, v); check("reset_data", v, 32'h0);
        apb_read(32'h8, v); check("reset_stat", v, 32'h0);
        apb_read(32'hC, v); check("reset_0xc", v, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("pready", {31'b0, pready}, 32'h1);
        check("pslverr", {31'b0, pslverr}, 32'h0);

        write_ctrl(32'h3);
        apb_read(32'h0, v); check("ctrl_rb", v, 32'h3);
        send_frame(8'h1C, 0);
        check_stat("one_byte_stat");
        check_irq("one_byte_irq");
        check_data("one_byte_data");
        check_stat("one_byte_empty");
        check_irq("one_byte_irq_off");

        send_frame(8'h1C, 1);
        check_stat("perr_set");
        write_stat(32'h4);
        check_stat("perr_clr");

        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 0);
        check_stat("full_ovf");
        for (int i = 0; i <= DEPTH; i++) check_data($sformatf("drain_%0d", i));
        write_stat(32'h2);
        check_stat("ovf_clr");

        write_ctrl(32'h0);
        send_frame(8'hF0, 0);
        check_stat("en_off");
        write_ctrl(32'h1);
        send_frame(8'hF0, 0);
        check_irq("itn_off_irq");
        check_stat("itn_off_stat");
        check_data("itn_off_data");

        send_bits(11'h7FF, 5);
        repeat (TMO + 50) @(negedge clk);
        send_frame(8'h5A, 0);
        check_data("timeout_data");
        check_stat("timeout_stat");

        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5)
                send_frame(8'($urandom_range(0, 255)),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            else if (r <= 7) check_data($sformatf("rnd_data_%0d", it));
            else if (r == 8) write_stat(32'($urandom_range(0, 7)));
            else write_ctrl(32'($urandom_range(0, 3)));
            check_stat($sformatf("rnd_stat_%0d", it));
            check_irq($sformatf("rnd_irq_%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
